// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial transmitter: WIDTH-bit words in over valid/ready,
// shifted out on x one bit per DIV clocks, with a one-entry holding
// register so consecutive words leave with no idle gap.
module serial_pattern_tx #(
  parameter int   WIDTH     = 8,
  parameter int   DIV       = 1,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic [WIDTH-1:0] shift_nxt;

  // The bit that leaves first from a word sitting in the shift register.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // ready depends only on registered state, so a source may tie valid to it freely.
  assign ready     = reset_n && !hold_full_q;
  assign busy      = (state_q == SHIFT) || hold_full_q;
  assign done      = (state_q == SHIFT) && (bit_cnt_q == BIT_LAST) && (div_cnt_q == DIV_LAST);
  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign shift_nxt = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

  // Next-state: hold->shift transfer, bit/div counting, and the accept path.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    x_d         = x_q;
    x_valid_d   = x_valid_q;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d     = SHIFT;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
          div_cnt_d   = '0;
          x_d         = first_bit(hold_q);
          x_valid_d   = 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt_q != DIV_LAST) begin
          div_cnt_d = div_cnt_q + DW'(1);
        end else if (bit_cnt_q != BIT_LAST) begin
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + BW'(1);
          shift_d   = shift_nxt;
          x_d       = first_bit(shift_nxt);
        end else if (hold_full_q) begin
          // Chain straight into the held word: x_valid never drops.
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
          div_cnt_d   = '0;
          x_d         = first_bit(hold_q);
        end else begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          x_d       = IDLE_BIT;
          x_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // ready is low whenever a transfer empties the register, so these never collide.
    if (valid && ready) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  // State register; reset aborts any word in flight and drops the held word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      x_q         <= IDLE_BIT;
      x_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: two instances (MSB-first DIV=1, LSB-first DIV=3),
// a cycle-count model compared every cycle, plus directed literal checks.
module tb_serial_pattern_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic       va, vb;
  logic [7:0] da, db;
  logic ready_a, x_a, xv_a, busy_a, done_a;
  logic ready_b, x_b, xv_b, busy_b, done_b;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .reset_n(rst_n), .data_in(da), .valid(va), .ready(ready_a),
    .x(x_a), .x_valid(xv_a), .busy(busy_a), .done(done_a));

  serial_pattern_tx #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_b (
    .clk(clk), .reset_n(rst_n), .data_in(db), .valid(vb), .ready(ready_b),
    .x(x_b), .x_valid(xv_b), .busy(busy_b), .done(done_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a word occupies the line for 8*DIV cycles; t counts cycles into it.
  typedef struct {
    bit         hf;
    logic [7:0] hold;
    bit         act;
    logic [7:0] word;
    int         t;
  } m_t;

  function automatic m_t mzero();
    m_t m;
    m.hf = 0; m.hold = '0; m.act = 0; m.word = '0; m.t = 0;
    return m;
  endfunction

  function automatic m_t mstep(input m_t m, input logic v, input logic [7:0] d, input int dv);
    m_t n = m;
    if (m.act) begin
      if (m.t == 8*dv - 1) begin
        if (m.hf) begin n.word = m.hold; n.t = 0; n.hf = 0; end
        else n.act = 0;
      end else n.t = m.t + 1;
    end else if (m.hf) begin
      n.act = 1; n.word = m.hold; n.t = 0; n.hf = 0;
    end
    if (v && !m.hf) begin n.hf = 1; n.hold = d; end
    return n;
  endfunction

  function automatic logic mx(input m_t m, input int dv, input bit msb);
    int idx;
    if (!m.act) return 1'b0;
    idx = m.t / dv;
    return msb ? m.word[7-idx] : m.word[idx];
  endfunction

  function automatic logic mdone(input m_t m, input int dv);
    return m.act && (m.t == 8*dv - 1);
  endfunction

  m_t ma = mzero();
  m_t mb = mzero();

  // Every-cycle compare of both instances against the model.
  always @(posedge clk) begin
    if (!rst_n) begin
      ma = mzero(); mb = mzero();
    end else begin
      ma = mstep(ma, va, da, 1);
      mb = mstep(mb, vb, db, 3);
    end
    #1;
    chk("a_x",     {31'd0, x_a},     {31'd0, mx(ma, 1, 1'b1)});
    chk("a_xv",    {31'd0, xv_a},    {31'd0, ma.act});
    chk("a_done",  {31'd0, done_a},  {31'd0, mdone(ma, 1)});
    chk("a_busy",  {31'd0, busy_a},  {31'd0, ma.act || ma.hf});
    chk("a_ready", {31'd0, ready_a}, {31'd0, rst_n && !ma.hf});
    chk("b_x",     {31'd0, x_b},     {31'd0, mx(mb, 3, 1'b0)});
    chk("b_xv",    {31'd0, xv_b},    {31'd0, mb.act});
    chk("b_done",  {31'd0, done_b},  {31'd0, mdone(mb, 3)});
    chk("b_busy",  {31'd0, busy_b},  {31'd0, mb.act || mb.hf});
    chk("b_ready", {31'd0, ready_b}, {31'd0, rst_n && !mb.hf});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    m_t pm;
    logic [7:0]  w;
    logic [23:0] got;
    int nb, nacc, stalls, ndone, bad_done, gap;
    bit acc;

    va = 1'b1; vb = 1'b1; da = 8'h5A; db = 8'h5A;

    // Pin the model with hand-computed values.
    pm = mzero(); pm.act = 1; pm.word = 8'hC8;
    pm.t = 0; chk("mdl_c8_t0", {31'd0, mx(pm, 1, 1'b1)}, 32'd1);
    pm.t = 2; chk("mdl_c8_t2", {31'd0, mx(pm, 1, 1'b1)}, 32'd0);
    pm.t = 7; chk("mdl_done7", {31'd0, mdone(pm, 1)}, 32'd1);
    pm.word = 8'h01;
    pm.t = 2; chk("mdl_01_t2", {31'd0, mx(pm, 3, 1'b0)}, 32'd1);
    pm.t = 3; chk("mdl_01_t3", {31'd0, mx(pm, 3, 1'b0)}, 32'd0);

    // Reset held with valid high.
    repeat (3) tick();
    chk("rst_ready", {31'd0, ready_a}, 32'd0);
    chk("rst_x",     {31'd0, x_a},     32'd0);
    chk("rst_xv",    {31'd0, xv_a},    32'd0);
    chk("rst_busy",  {31'd0, busy_a},  32'd0);
    chk("rst_done",  {31'd0, done_a},  32'd0);
    chk("rst_b_rdy", {31'd0, ready_b}, 32'd0);
    va = 1'b0; vb = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, ready_a}, 32'd1);
    chk("post_rst_busy",  {31'd0, busy_a},  32'd0);

    // Single word C8, MSB first, DIV=1.
    w = 8'hC8;
    va = 1'b1; da = w;
    tick();
    va = 1'b0;
    chk("sw_busy_held", {31'd0, busy_a}, 32'd1);
    chk("sw_xv_pre",    {31'd0, xv_a},   32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("sw_x",    {31'd0, x_a},    {31'd0, w[7-i]});
      chk("sw_xv",   {31'd0, xv_a},   32'd1);
      chk("sw_done", {31'd0, done_a}, (i == 7) ? 32'd1 : 32'd0);
    end
    tick();
    chk("sw_x_end",    {31'd0, x_a},    32'd0);
    chk("sw_xv_end",   {31'd0, xv_a},   32'd0);
    chk("sw_busy_end", {31'd0, busy_a}, 32'd0);

    // Back-to-back with backpressure: C8, 35, AA presented with valid held.
    va = 1'b1; da = 8'hC8;
    nb = 0; nacc = 0; stalls = 0; ndone = 0; bad_done = 0; gap = 0; got = '0;
    for (int c = 0; c < 40; c++) begin
      acc = va && ready_a;
      if (va && !ready_a) stalls++;
      tick();
      if (acc) begin
        nacc++;
        if (nacc == 1) da = 8'h35;
        else if (nacc == 2) da = 8'hAA;
        else va = 1'b0;
      end
      if (xv_a && nb < 24) begin
        got = {got[22:0], x_a};
        nb++;
        if (done_a) begin
          ndone++;
          if (nb % 8 != 0) bad_done++;
        end else if (nb % 8 == 0) bad_done++;
      end else if (!xv_a && nb > 0 && nb < 24) gap++;
    end
    chk("b2b_bits",   got,    24'hC835AA);
    chk("b2b_nbits",  nb,     32'd24);
    chk("b2b_gap",    gap,    32'd0);
    chk("b2b_ndone",  ndone,  32'd3);
    chk("b2b_dpos",   bad_done, 32'd0);
    chk("b2b_nacc",   nacc,   32'd3);
    chk("b2b_stall",  {31'd0, stalls > 0}, 32'd1);
    chk("b2b_idle",   {31'd0, busy_a}, 32'd0);

    // DIV=3, LSB first, word 01 on instance b.
    vb = 1'b1; db = 8'h01;
    tick();
    vb = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("d3_x",    {31'd0, x_b},    (i < 3) ? 32'd1 : 32'd0);
      chk("d3_xv",   {31'd0, xv_b},   32'd1);
      chk("d3_done", {31'd0, done_b}, (i == 23) ? 32'd1 : 32'd0);
    end
    tick();
    chk("d3_xv_end",   {31'd0, xv_b},   32'd0);
    chk("d3_busy_end", {31'd0, busy_b}, 32'd0);

    // Reset mid-word with a second word held.
    va = 1'b1; da = 8'hFF;
    tick();              // FF accepted
    da = 8'h0F;
    tick();              // FF moves to shifter, bit 0 out
    tick();              // 0F accepted, bit 1 out
    va = 1'b0;
    tick();              // bit 2
    tick();              // bit 3
    chk("mid_x_pre",     {31'd0, x_a},     32'd1);
    chk("mid_ready_pre", {31'd0, ready_a}, 32'd0);
    chk("mid_busy_pre",  {31'd0, busy_a},  32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_x_async",     {31'd0, x_a},     32'd0);
    chk("mid_xv_async",    {31'd0, xv_a},    32'd0);
    chk("mid_busy_async",  {31'd0, busy_a},  32'd0);
    chk("mid_ready_async", {31'd0, ready_a}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mid_post_xv",   {31'd0, xv_a},    32'd0);
      chk("mid_post_busy", {31'd0, busy_a},  32'd0);
      chk("mid_post_rdy",  {31'd0, ready_a}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Parallel-to-serial bit-stream transmitter, the source side of the team's serial pattern detectors. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit at a time on x, holding each bit for DIV clock cycles. A one-entry holding register allows back-to-back words with no idle gap on x. It drives detector inputs in the design and in benches.

Parameters:
WIDTH, 8, bits per word; legal range 2..32.
DIV, 1, clock cycles per bit; legal range 1..256.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
IDLE_BIT, 0, value driven on x when no word is being sent.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
data_in  input  WIDTH  word to transmit.
valid  input  1  data_in is valid.
ready  output  1  block can accept a word this cycle.
x  output  1  serial bit out (registered).
x_valid  output  1  high while x carries a word bit.
busy  output  1  shifter active or holding register full.
done  output  1  one-cycle pulse on the final cycle of each word's last bit.

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous, active-low.
- Reset (reset_n low, asynchronous): x=IDLE_BIT, x_valid=0, busy=0, done=0, ready=0, holding register empty, state IDLE, all counters 0.
- After reset_n deasserts, ready=1 from the first clock edge.
- ready = reset_n and holding register empty. ready is combinational from registered state only, never from valid.
- Accept: on an edge with valid&&ready, data_in is copied into the holding register. If valid is high while ready is low, data_in is ignored and nothing is lost.
- FSM states: IDLE, SHIFT.
- IDLE: x=IDLE_BIT, x_valid=0. If the holding register is full at an edge, move the word to the shift register, empty the holding register, set bit_cnt=0 and div_cnt=0, and enter SHIFT.
- Latency: a word accepted at edge k appears on x (first bit, x_valid=1) after edge k+1.
- SHIFT: x and x_valid are registered and change only on bit boundaries.
  - div_cnt counts 0..DIV-1. When div_cnt=DIV-1, the next bit is presented and bit_cnt increments.
  - Each bit is stable for exactly DIV cycles.
- Last bit: the cycle with bit_cnt=WIDTH-1 and div_cnt=DIV-1.
  - done=1 for that one cycle.
  - At the following edge, if the holding register is full: load the held word, stay in SHIFT, and present its first bit. There is no gap; x_valid stays 1.
  - Otherwise go to IDLE, with x=IDLE_BIT and x_valid=0.
- Simultaneous events: accepting a new word and transferring hold→shift on the same edge cannot happen, because ready=0 whenever the holding register is full. ready rises the cycle after a transfer.
- busy = (state==SHIFT) or holding register full. busy is 0 exactly when IDLE with an empty holding register.
- Bit order: with MSB_FIRST=1, data_in[WIDTH-1] is sent first; with MSB_FIRST=0, data_in[0] is sent first.
- Counter widths: bit_cnt is ceil(log2(WIDTH)) bits and div_cnt is ceil(log2(DIV)) bits (minimum 1). Neither counter wraps except by explicit reset to 0.
- Reset mid-word: the transmission aborts immediately and the held word is discarded. There is no partial-word resume.

Test Plan:
- Reset: hold reset_n=0 with valid=1 → ready=0, x=0, x_valid=0, busy=0. Release → ready=1 next cycle.
- Single word (WIDTH=8, DIV=1, MSB_FIRST=1): accept 8'hC8 at edge k → x=1,1,0,0,1,0,0,0 on cycles k+1..k+8 with x_valid=1 throughout; done on cycle k+8; x=0 and busy=0 from k+9.
- Back-to-back: present 8'hC8 then 8'h35 with valid held high → second accept when ready rises. x carries 16 contiguous bits 11001000 00110101 with no x_valid gap; two done pulses 8 cycles apart.
- Backpressure: valid=1 with data 8'hAA while the holding register is full → ready=0. The word is accepted only after the transfer; no word is lost or duplicated (scoreboard compare).
- DIV=3, MSB_FIRST=0, word 8'h01 → x=1 for 3 cycles, then 0 for 21 cycles; done asserted only on cycle 24.
- Reset mid-word: assert reset_n=0 after bit 3 → x=IDLE_BIT and x_valid=0 immediately (asynchronous). After release, the held word is gone and busy=0.
